// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: FSM encoding, default sizing, op codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsq_pkg;

    // Execution FSM: wait for work, run the RAM access, hold a load result for the CDB.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        WAIT_CDB = 2'd2
    } lsqState_t;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_LABEL_W = 4;
    localparam int DEFAULT_ADDR_W  = 8;
    localparam int DEFAULT_MEM_LAT = 2;

    localparam logic OP_LOAD  = 1'b1;
    localparam logic OP_STORE = 1'b0;

    // Width of the access-latency down-counter; it never holds more than lat-1.
    function automatic int latWidth(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/lsq_ram.sv
// Data RAM behind the load/store queue: 2^ADDR_W words of 32 bits, no reset on contents.
// Latency: write lands on the clock edge with we high; read is combinational.
// Backpressure: none, accepts a write every cycle.
//
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   addr   word address shared by read and write
//   wdata  write data
//   rdata  combinational read of mem[addr]
module lsq_ram
    import lsq_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: buffers issued memory ops and executes them one at a time against lsq_ram.
// Latency: issue at edge 0 -> access starts edge 1 -> st_done / cdb_req after edge 1+MEM_LAT.
// Backpressure: issue_ready drops when DEPTH entries are held; a load result waits in WAIT_CDB until cdb_ack.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   issue_valid/issue_ready        issue handshake; issue_op 1=load 0=store
//   issue_base, issue_offset       address operands, effective address is their 32-bit sum
//   issue_data, issue_label        store data and reservation-station tag
//   cdb_req/cdb_label/cdb_data     load result offered to the common data bus, held until cdb_ack
//   st_done/st_label               one-cycle store completion pulse and its tag
//   count, busy                    occupancy and (count != 0)
module load_store_queue
    import lsq_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LABEL_W = DEFAULT_LABEL_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic                     issue_op,
    input  logic [31:0]              issue_base,
    input  logic [31:0]              issue_offset,
    input  logic [31:0]              issue_data,
    input  logic [LABEL_W-1:0]       issue_label,

    output logic                     cdb_req,
    output logic [LABEL_W-1:0]       cdb_label,
    output logic [31:0]              cdb_data,
    input  logic                     cdb_ack,

    output logic                     st_done,
    output logic [LABEL_W-1:0]       st_label,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = latWidth(MEM_LAT);

    // ---------------------------------------------------------------
    // Queue storage (no reset needed: validity is tracked by countQ)
    // ---------------------------------------------------------------
    logic                opQ    [DEPTH];
    logic [ADDR_W-1:0]   wordQ  [DEPTH];
    logic [31:0]         dataQ  [DEPTH];
    logic [LABEL_W-1:0]  labelQ [DEPTH];

    logic [PTR_W-1:0]    headPtr;
    logic [PTR_W-1:0]    tailPtr;
    logic [CNT_W-1:0]    countQ;
    logic [LAT_W-1:0]    latCnt;

    lsqState_t           state;
    lsqState_t           stateNext;

    logic                isPush;
    logic                isPop;
    logic                accessDone;
    logic                storeRetire;
    logic                latchLoad;
    logic                ramWe;
    logic [31:0]         ramRdata;

    logic [31:0]         issueAddr;
    logic                unusedAddrBits;

    // Only the word-address bits reach the queue; byte offset and high bits are dropped here.
    assign issueAddr      = issue_base + issue_offset;
    assign unusedAddrBits = ^{issueAddr[31:ADDR_W+2], issueAddr[1:0]};

    // Ready is based on the registered count only, so a full queue stays closed
    // even on an edge where the head retires.
    assign issue_ready = (countQ < CNT_W'(DEPTH));
    assign isPush      = issue_valid && issue_ready;

    assign accessDone  = (state == ACCESS) && (latCnt == '0);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (countQ != '0) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                if (latCnt == '0) begin
                    stateNext = (opQ[headPtr] == OP_LOAD) ? WAIT_CDB : IDLE;
                end
            end
            WAIT_CDB: begin
                if (cdb_ack) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: output / control decode
    // ---------------------------------------------------------------
    always_comb begin
        storeRetire = 1'b0;
        latchLoad   = 1'b0;
        isPop       = 1'b0;
        ramWe       = 1'b0;
        if (accessDone) begin
            if (opQ[headPtr] == OP_STORE) begin
                storeRetire = 1'b1;
                isPop       = 1'b1;
                // A reset on the completion edge aborts the access, so the RAM
                // (which is not reset) must not be written on that edge.
                ramWe       = rst_n;
            end else begin
                latchLoad   = 1'b1;
            end
        end
        // cdb_ack is only meaningful while a result is actually being offered.
        if ((state == WAIT_CDB) && cdb_ack) begin
            isPop = 1'b1;
        end
    end

    assign cdb_req = (state == WAIT_CDB);
    assign count   = countQ;
    assign busy    = (countQ != '0);

    // ---------------------------------------------------------------
    // Queue bookkeeping, latency counter and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            countQ    <= '0;
            latCnt    <= '0;
            st_done   <= 1'b0;
            st_label  <= '0;
            cdb_label <= '0;
            cdb_data  <= '0;
        end else begin
            if (isPush) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (isPop) begin
                headPtr <= headPtr + PTR_W'(1);
            end

            case ({isPush, isPop})
                2'b10:   countQ <= countQ + CNT_W'(1);
                2'b01:   countQ <= countQ - CNT_W'(1);
                default: countQ <= countQ;
            endcase

            // Loaded on the IDLE->ACCESS edge, so ACCESS lasts exactly MEM_LAT cycles.
            if ((state == IDLE) && (countQ != '0)) begin
                latCnt <= LAT_W'(MEM_LAT - 1);
            end else if ((state == ACCESS) && (latCnt != '0)) begin
                latCnt <= latCnt - LAT_W'(1);
            end

            st_done <= storeRetire;
            if (storeRetire) begin
                st_label <= labelQ[headPtr];
            end

            // In-order execution means every older store is already in the RAM here.
            if (latchLoad) begin
                cdb_data  <= ramRdata;
                cdb_label <= labelQ[headPtr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (isPush) begin
            opQ[tailPtr]    <= issue_op;
            wordQ[tailPtr]  <= issueAddr[ADDR_W+1:2];
            dataQ[tailPtr]  <= issue_data;
            labelQ[tailPtr] <= issue_label;
        end
    end

    // ---------------------------------------------------------------
    // Data RAM: always addressed by the head entry
    // ---------------------------------------------------------------
    lsq_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ramWe),
        .addr  (wordQ[headPtr]),
        .wdata (dataQ[headPtr]),
        .rdata (ramRdata)
    );

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: main build (MEM_LAT=2) plus MEM_LAT=1 and MEM_LAT=4 builds
// driven by the same stimulus; only the main build is checked beyond the latency test.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_load_store_queue;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_op;
    logic [31:0]   issue_base;
    logic [31:0]   issue_offset;
    logic [31:0]   issue_data;
    logic [LW-1:0] issue_label;
    logic          cdb_ack;

    logic          issue_ready, cdb_req, st_done, busy;
    logic [LW-1:0] cdb_label, st_label;
    logic [31:0]   cdb_data;
    logic [2:0]    count;

    logic          issueReady1, cdbReq1, stDone1, busy1;
    logic [LW-1:0] cdbLabel1, stLabel1;
    logic [31:0]   cdbData1;
    logic [2:0]    count1;

    logic          issueReady4, cdbReq4, stDone4, busy4;
    logic [LW-1:0] cdbLabel4, stLabel4;
    logic [31:0]   cdbData4;
    logic [2:0]    count4;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    load_store_queue #(.DEPTH(4), .LABEL_W(LW), .ADDR_W(8), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_base(issue_base), .issue_offset(issue_offset), .issue_data(issue_data),
        .issue_label(issue_label),
        .cdb_req(cdb_req), .cdb_label(cdb_label), .cdb_data(cdb_data), .cdb_ack(cdb_ack),
        .st_done(st_done), .st_label(st_label), .count(count), .busy(busy)
    );

    load_store_queue #(.DEPTH(4), .LABEL_W(LW), .ADDR_W(8), .MEM_LAT(1)) dutLat1 (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issueReady1), .issue_op(issue_op),
        .issue_base(issue_base), .issue_offset(issue_offset), .issue_data(issue_data),
        .issue_label(issue_label),
        .cdb_req(cdbReq1), .cdb_label(cdbLabel1), .cdb_data(cdbData1), .cdb_ack(cdb_ack),
        .st_done(stDone1), .st_label(stLabel1), .count(count1), .busy(busy1)
    );

    load_store_queue #(.DEPTH(4), .LABEL_W(LW), .ADDR_W(8), .MEM_LAT(4)) dutLat4 (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issueReady4), .issue_op(issue_op),
        .issue_base(issue_base), .issue_offset(issue_offset), .issue_data(issue_data),
        .issue_label(issue_label),
        .cdb_req(cdbReq4), .cdb_label(cdbLabel4), .cdb_data(cdbData4), .cdb_ack(cdb_ack),
        .st_done(stDone4), .st_label(stLabel4), .count(count4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIssue(input logic op, input logic [31:0] base, input logic [31:0] off,
                            input logic [31:0] data, input logic [LW-1:0] label);
        issue_op     = op;
        issue_base   = base;
        issue_offset = off;
        issue_data   = data;
        issue_label  = label;
    endtask

    // Waits (bounded) for space, then presents the entry for exactly one edge.
    task automatic issueOne(input logic op, input logic [31:0] base, input logic [31:0] off,
                            input logic [31:0] data, input logic [LW-1:0] label);
        int n = 0;
        while (!issue_ready && n < 50) begin
            tick();
            n++;
        end
        chk("issueReadyWait", {31'd0, issue_ready}, 32'd1);
        setIssue(op, base, off, data, label);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    // Waits (bounded) for a load result, checks it, then acks it for one edge.
    task automatic drainOne(input logic [LW-1:0] expLabel, input logic [31:0] expData,
                            input logic checkData);
        int n = 0;
        while (!cdb_req && n < 50) begin
            tick();
            n++;
        end
        chk("cdbReqWait", {31'd0, cdb_req}, 32'd1);
        chk("drainLabel", {28'd0, cdb_label}, {28'd0, expLabel});
        if (checkData) begin
            chk("drainData", cdb_data, expData);
        end
        cdb_ack = 1'b1;
        tick();
        cdb_ack = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("idleWait", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        cdb_ack     = 1'b0;
        setIssue(1'b0, 32'd0, 32'd0, 32'd0, '0);
        tick();
        tick();
        rst_n = 1'b1;

        // ---- reset state ----
        chk("rstReady",  {31'd0, issue_ready}, 32'd1);
        chk("rstBusy",   {31'd0, busy},        32'd0);
        chk("rstCount",  {29'd0, count},       32'd0);
        chk("rstCdbReq", {31'd0, cdb_req},     32'd0);
        chk("rstStDone", {31'd0, st_done},     32'd0);

        // ---- latency per build: one load issued at edge 0 ----
        setIssue(1'b1, 32'h0, 32'h0, 32'h0, 4'd1);
        issue_valid = 1'b1;
        tick();                                   // edge 0
        issue_valid = 1'b0;
        tick();                                   // edge 1
        chk("lat1Edge1", {31'd0, cdbReq1}, 32'd0);
        tick();                                   // edge 2
        chk("lat1Edge2", {31'd0, cdbReq1}, 32'd1);
        chk("lat1Label", {28'd0, cdbLabel1}, 32'd1);
        chk("lat2Edge2", {31'd0, cdb_req}, 32'd0);
        tick();                                   // edge 3
        chk("lat2Edge3", {31'd0, cdb_req}, 32'd1);
        tick();                                   // edge 4
        chk("lat4Edge4", {31'd0, cdbReq4}, 32'd0);
        tick();                                   // edge 5
        chk("lat4Edge5", {31'd0, cdbReq4}, 32'd1);
        cdb_ack = 1'b1;
        tick();
        cdb_ack = 1'b0;
        chk("latAckReq",   {31'd0, cdb_req}, 32'd0);
        chk("latAckCount", {29'd0, count},   32'd0);

        // ---- store then load of the same word ----
        setIssue(1'b0, 32'h10, 32'h4, 32'hDEADBEEF, 4'd3);
        issue_valid = 1'b1;
        tick();                                   // edge 0
        setIssue(1'b1, 32'h14, 32'h0, 32'h0, 4'd5);
        tick();                                   // edge 1
        issue_valid = 1'b0;
        chk("stldCount", {29'd0, count}, 32'd2);
        tick();                                   // edge 2
        chk("stDoneEarly", {31'd0, st_done}, 32'd0);
        tick();                                   // edge 3
        chk("stDone",  {31'd0, st_done},  32'd1);
        chk("stLabel", {28'd0, st_label}, 32'd3);
        tick();                                   // edge 4
        chk("stDonePulse", {31'd0, st_done}, 32'd0);
        tick();                                   // edge 5
        chk("ldReqEarly", {31'd0, cdb_req}, 32'd0);
        tick();                                   // edge 6
        chk("ldReq",   {31'd0, cdb_req},   32'd1);
        chk("ldData",  cdb_data,           32'hDEADBEEF);
        chk("ldLabel", {28'd0, cdb_label}, 32'd5);
        chk("ldCount", {29'd0, count},     32'd1);

        // ---- result held without ack ----
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("holdReq",   {31'd0, cdb_req},   32'd1);
            chk("holdData",  cdb_data,           32'hDEADBEEF);
            chk("holdLabel", {28'd0, cdb_label}, 32'd5);
        end
        cdb_ack = 1'b1;
        tick();
        cdb_ack = 1'b0;
        chk("ackReqLow", {31'd0, cdb_req}, 32'd0);
        chk("ackCount",  {29'd0, count},   32'd0);
        chk("ackBusy",   {31'd0, busy},    32'd0);

        // ---- fill to DEPTH with loads, reject a 5th even on a retire edge ----
        for (int i = 0; i < 4; i++) begin
            setIssue(1'b1, 32'h100 + 32'(4 * i), 32'h0, 32'h0, LW'(10 + i));
            issue_valid = 1'b1;
            chk("fillReady", {31'd0, issue_ready}, 32'd1);
            tick();
        end
        chk("fullCount", {29'd0, count},       32'd4);
        chk("fullReady", {31'd0, issue_ready}, 32'd0);
        setIssue(1'b1, 32'h200, 32'h0, 32'h0, 4'd14);
        tick();
        chk("fullReject", {29'd0, count}, 32'd4);
        chk("fullHeadReq", {31'd0, cdb_req}, 32'd1);
        chk("fullHeadLabel", {28'd0, cdb_label}, 32'd10);
        cdb_ack = 1'b1;                           // retire and issue on the same edge
        tick();
        cdb_ack     = 1'b0;
        issue_valid = 1'b0;
        chk("retireCount", {29'd0, count},       32'd3);
        chk("retireReady", {31'd0, issue_ready}, 32'd1);
        drainOne(4'd11, 32'h0, 1'b0);
        drainOne(4'd12, 32'h0, 1'b0);
        drainOne(4'd13, 32'h0, 1'b0);
        chk("fullDrained", {29'd0, count}, 32'd0);

        // ---- 10 entries through the queue: pointer wrap and FIFO order ----
        for (int i = 0; i < 5; i++) begin
            // high bits and byte offset must be ignored: word 0x30+i
            issueOne(1'b0, 32'hFFFF_0000 + 32'(4 * (8'h30 + i)), 32'h2,
                     32'h1000 + 32'(i), LW'(i));
        end
        // 0xFFFFFFFF + 0xC1 wraps to 0xC0 -> word 0x30
        issueOne(1'b1, 32'hFFFF_FFFF, 32'hC1, 32'h0, 4'd8);
        for (int i = 1; i < 4; i++) begin
            issueOne(1'b1, 32'(4 * (8'h30 + i)), 32'h0, 32'h0, LW'(8 + i));
        end
        for (int i = 0; i < 5; i++) begin
            drainOne(LW'(8 + i), 32'h1000 + 32'(i), 1'b1);
            if (i == 0) begin
                issueOne(1'b1, 32'(4 * 8'h34), 32'h0, 32'h0, 4'd12);
            end
        end
        chk("wrapCount", {29'd0, count}, 32'd0);
        chk("wrapBusy",  {31'd0, busy},  32'd0);

        // ---- reset during a store access leaves the RAM untouched ----
        issueOne(1'b0, 32'd28, 32'd0, 32'h7777_0007, 4'd9);
        waitIdle();
        chk("preRstStLabel", {28'd0, st_label}, 32'd9);
        setIssue(1'b0, 32'd28, 32'd0, 32'h0000_0BAD, 4'd6);
        issue_valid = 1'b1;
        tick();                                   // edge 0
        issue_valid = 1'b0;
        tick();                                   // edge 1: ACCESS
        rst_n = 1'b0;
        tick();                                   // edge 2: reset mid-access
        rst_n = 1'b1;
        chk("abortCount",    {29'd0, count},       32'd0);
        chk("abortBusy",     {31'd0, busy},        32'd0);
        chk("abortReady",    {31'd0, issue_ready}, 32'd1);
        chk("abortStDone",   {31'd0, st_done},     32'd0);
        chk("abortStLabel",  {28'd0, st_label},    32'd0);
        chk("abortCdbReq",   {31'd0, cdb_req},     32'd0);
        chk("abortCdbLabel", {28'd0, cdb_label},   32'd0);
        chk("abortCdbData",  cdb_data,             32'd0);
        tick();                                   // edge 3: would-be completion
        chk("abortNoStDone", {31'd0, st_done}, 32'd0);
        issueOne(1'b1, 32'd28, 32'd0, 32'h0, 4'd2);
        drainOne(4'd2, 32'h7777_0007, 1'b1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
